result_arbiter: RTL

Writeback arbiter sitting between the execution units and the results buffer. It buffers completed results from up to NUM_SRC execution units in small per-source FIFOs and drives the single-lane results-buffer input (rob_transmit, robid, flags, wbs, value), at most one result per cycle. Source selection is round-robin. A flush input discards all buffered results on branch redirect.

---
 rtl/result_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/result_arbiter.sv
// result_arbiter: round-robin writeback arbiter from NUM_SRC per-source FIFOs onto one results-buffer lane.
// Optional feature macro RESULT_ARB_BRANCH_PRIO_EN: branch heads win arbitration over non-branch heads.
module result_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic [4*NUM_SRC-1:0]   src_robid,
    input  logic [8*NUM_SRC-1:0]   src_flags,
    input  logic [8*NUM_SRC-1:0]   src_wbs,
    input  logic [8*NUM_SRC-1:0]   src_value,
    output logic                   rob_transmit,
    output logic [3:0]             robid,
    output logic [7:0]             flags,
    output logic [7:0]             wbs,
    output logic [7:0]             value,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(NUM_SRC);

    logic [27:0]        mem_q [NUM_SRC][DEPTH];
    logic [27:0]        head  [NUM_SRC];
    logic [AW-1:0]      wr_q  [NUM_SRC];
    logic [AW-1:0]      wr_d  [NUM_SRC];
    logic [AW-1:0]      rd_q  [NUM_SRC];
    logic [AW-1:0]      rd_d  [NUM_SRC];
    logic [CW-1:0]      cnt_q [NUM_SRC];
    logic [CW-1:0]      cnt_d [NUM_SRC];
    logic [SW-1:0]      rr_q, rr_d, gnt, idx;
    logic               gnt_v, tx_q, tx_d;
    logic [27:0]        out_q, out_d;
    logic [NUM_SRC-1:0] push, pop, cand, sel;

    // Per-source handshake: ready depends only on fill level; flush drops pushes
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = rst_n && (cnt_q[i] != CW'(DEPTH));
            push[i]      = src_valid[i] && src_ready[i] && !flush;
            head[i]      = mem_q[i][rd_q[i]];
            cand[i]      = cnt_q[i] != '0;
        end
    end

    assign busy = |cand;

`ifdef RESULT_ARB_BRANCH_PRIO_EN
    logic [NUM_SRC-1:0] br;

    // Branch heads (flags bit0) form a priority group searched before the rest
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) br[i] = head[i][16];
        sel = |(cand & br) ? (cand & br) : cand;
    end
`else
    assign sel = cand;
`endif

    // Round-robin search upward from rr, first selected source wins
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SW'((int'(rr_q) + k) % NUM_SRC);
            if (!gnt_v && sel[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Next state: grant suppressed by flush, which also empties every FIFO but keeps rr
    always_comb begin
        tx_d  = gnt_v && !flush;
        rr_d  = tx_d ? ((gnt == SW'(NUM_SRC - 1)) ? '0 : gnt + SW'(1)) : rr_q;
        out_d = tx_d ? head[gnt] : out_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]   = tx_d && (gnt == SW'(i));
            cnt_d[i] = flush ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_d[i]  = flush ? '0 : wr_q[i] + AW'(push[i]);
            rd_d[i]  = flush ? '0 : rd_q[i] + AW'(pop[i]);
        end
    end

    // Control state and registered output bus with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
            rr_q  <= '0;
            tx_q  <= 1'b0;
            out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
            end
            rr_q  <= rr_d;
            tx_q  <= tx_d;
            out_q <= out_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the counts
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i])
                mem_q[i][wr_q[i]] <= {src_robid[4*i +: 4], src_flags[8*i +: 8], src_wbs[8*i +: 8], src_value[8*i +: 8]};
        end
    end

    assign rob_transmit = tx_q;
    assign {robid, flags, wbs, value} = out_q;
endmodule
